// File: rtl/fe_pow_engine.sv
// fe_pow_engine: computes x^e mod P with left-to-right square-and-multiply,
// using an external modular multiplier through a val/rdy request/response pair.
//
// Ports:
//   i_clk, i_rst_n            clock (rising edge), asynchronous active-low reset
//   i_req_*  / o_req_rdy      operation request: x, exponent, tag, mode (0 inverse, 1 power)
//   o_mul_*  / i_mul_rdy      multiplier request, o_mul_dat = {b, a}, tag = latched request tag
//   i_mul_*  / o_mul_rdy      multiplier response (a*b mod P)
//   o_res_*  / i_res_rdy      result and its tag, held until accepted
//   o_busy                    high whenever the engine is not idle
//
// Build option: define FE_POW_CONST_TIME_EN to walk every exponent bit from EXP_BITS-1
// down with one square and one multiply each (result of the multiply dropped on zero
// bits), giving a data-independent 2*EXP_BITS multiplier transactions per operation.
module fe_pow_engine #(
    parameter int unsigned         DAT_BITS = 381,
    parameter logic [DAT_BITS-1:0] P        = 381'h1a0111ea_397fe69a_4b1ba7b6_434bacd7_64774b84_f38512bf_6730d2a0_f6b0f624_1eabfffe_b153ffff_b9feffff_ffffaaab,
    parameter int unsigned         EXP_BITS = DAT_BITS,
    parameter int unsigned         CTL_BITS = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,

    input  logic                  i_req_val,
    output logic                  o_req_rdy,
    input  logic [DAT_BITS-1:0]   i_req_dat,
    input  logic [EXP_BITS-1:0]   i_req_exp,
    input  logic [CTL_BITS-1:0]   i_req_ctl,
    input  logic                  i_req_mode,

    output logic                  o_mul_val,
    input  logic                  i_mul_rdy,
    output logic [2*DAT_BITS-1:0] o_mul_dat,
    output logic [CTL_BITS-1:0]   o_mul_ctl,

    input  logic                  i_mul_val,
    output logic                  o_mul_rdy,
    input  logic [DAT_BITS-1:0]   i_mul_dat,

    output logic                  o_res_val,
    input  logic                  i_res_rdy,
    output logic [DAT_BITS-1:0]   o_res_dat,
    output logic [CTL_BITS-1:0]   o_res_ctl,

    output logic                  o_busy
);

    localparam int unsigned         PTR_BITS = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
    localparam logic [DAT_BITS-1:0] P_M2     = P - DAT_BITS'(2);
    localparam logic [DAT_BITS-1:0] ONE      = DAT_BITS'(1);

    typedef enum logic [2:0] {
        StIdle,
        StSqrReq,
        StSqrWait,
        StMulReq,
        StMulWait,
        StDone
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DAT_BITS-1:0]   r_x;
    logic [DAT_BITS-1:0]   w_x_nxt;
    logic [EXP_BITS-1:0]   r_e;
    logic [EXP_BITS-1:0]   w_e_nxt;
    logic [CTL_BITS-1:0]   r_ctl;
    logic [CTL_BITS-1:0]   w_ctl_nxt;
    logic [DAT_BITS-1:0]   r_r;
    logic [DAT_BITS-1:0]   w_r_nxt;
    logic [PTR_BITS-1:0]   r_ptr;
    logic [PTR_BITS-1:0]   w_ptr_nxt;
    // Keeps o_req_rdy low through reset and for the edge that releases it.
    logic                  r_rdy_en;

    logic [EXP_BITS-1:0]   w_exp;
    logic                  w_bit;

    // Inverse mode uses Fermat: x^(P-2). Truncated if EXP_BITS < DAT_BITS.
    assign w_exp = i_req_mode ? i_req_exp : EXP_BITS'(P_M2);
    assign w_bit = r_e[r_ptr];

`ifndef FE_POW_CONST_TIME_EN
    logic [PTR_BITS-1:0]   w_msb;
    logic                  w_exp_zero;

    assign w_exp_zero = (w_exp == '0);

    // Highest set bit of the incoming exponent; last match in the loop wins.
    always_comb begin
        w_msb = '0;
        for (int i = 0; i < EXP_BITS; i++) begin
            if (w_exp[i]) begin
                w_msb = PTR_BITS'(i);
            end
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_x      <= '0;
            r_e      <= '0;
            r_ctl    <= '0;
            r_r      <= '0;
            r_ptr    <= '0;
            r_rdy_en <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_x      <= w_x_nxt;
            r_e      <= w_e_nxt;
            r_ctl    <= w_ctl_nxt;
            r_r      <= w_r_nxt;
            r_ptr    <= w_ptr_nxt;
            r_rdy_en <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_e_nxt     = r_e;
        w_ctl_nxt   = r_ctl;
        w_r_nxt     = r_r;
        w_ptr_nxt   = r_ptr;
        o_req_rdy   = 1'b0;
        o_mul_val   = 1'b0;
        o_mul_rdy   = 1'b0;
        o_res_val   = 1'b0;
        o_busy      = 1'b1;

        unique case (r_state)
            StIdle: begin
                o_busy    = 1'b0;
                o_req_rdy = r_rdy_en;
                if (i_req_val && r_rdy_en) begin
                    w_x_nxt   = i_req_dat;
                    w_e_nxt   = w_exp;
                    w_ctl_nxt = i_req_ctl;
`ifdef FE_POW_CONST_TIME_EN
                    w_r_nxt     = ONE;
                    w_ptr_nxt   = PTR_BITS'(EXP_BITS - 1);
                    w_state_nxt = StSqrReq;
`else
                    // The MSB itself is consumed by r = x, so walking starts one below it.
                    w_r_nxt   = i_req_dat;
                    w_ptr_nxt = w_msb - PTR_BITS'(1);
                    if (w_exp_zero) begin
                        w_r_nxt     = ONE;
                        w_state_nxt = StDone;
                    end else if (w_msb == '0) begin
                        w_state_nxt = StDone;
                    end else begin
                        w_state_nxt = StSqrReq;
                    end
`endif
                end
            end

            StSqrReq: begin
                o_mul_val = 1'b1;
                if (i_mul_rdy) begin
                    w_state_nxt = StSqrWait;
                end
            end

            StSqrWait: begin
                o_mul_rdy = 1'b1;
                if (i_mul_val) begin
                    w_r_nxt = i_mul_dat;
`ifdef FE_POW_CONST_TIME_EN
                    w_state_nxt = StMulReq;
`else
                    if (w_bit) begin
                        w_state_nxt = StMulReq;
                    end else if (r_ptr == '0) begin
                        w_state_nxt = StDone;
                    end else begin
                        w_ptr_nxt   = r_ptr - PTR_BITS'(1);
                        w_state_nxt = StSqrReq;
                    end
`endif
                end
            end

            StMulReq: begin
                o_mul_val = 1'b1;
                if (i_mul_rdy) begin
                    w_state_nxt = StMulWait;
                end
            end

            StMulWait: begin
                o_mul_rdy = 1'b1;
                if (i_mul_val) begin
`ifdef FE_POW_CONST_TIME_EN
                    // Dummy multiply on a zero bit: response consumed, result dropped.
                    if (w_bit) begin
                        w_r_nxt = i_mul_dat;
                    end
`else
                    w_r_nxt = i_mul_dat;
`endif
                    if (r_ptr == '0) begin
                        w_state_nxt = StDone;
                    end else begin
                        w_ptr_nxt   = r_ptr - PTR_BITS'(1);
                        w_state_nxt = StSqrReq;
                    end
                end
            end

            StDone: begin
                o_res_val = 1'b1;
                if (i_res_rdy) begin
                    w_state_nxt = StIdle;
                end
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Upper half is the multiplicand b: x for a multiply step, r for a square.
    assign o_mul_dat = {((r_state == StMulReq) ? r_x : r_r), r_r};
    assign o_mul_ctl = r_ctl;
    assign o_res_dat = r_r;
    assign o_res_ctl = r_ctl;

endmodule

// File: tb/tb_fe_pow_engine.sv
module tb_fe_pow_engine;

    localparam int unsigned DB = 381;
    localparam int unsigned EB = 381;
    localparam int unsigned CB = 64;
    localparam logic [DB-1:0] P = 381'h1a0111ea_397fe69a_4b1ba7b6_434bacd7_64774b84_f38512bf_6730d2a0_f6b0f624_1eabfffe_b153ffff_b9feffff_ffffaaab;

    logic            clk = 1'b0;
    logic            i_rst_n;
    logic            i_req_val;
    logic            o_req_rdy;
    logic [DB-1:0]   i_req_dat;
    logic [EB-1:0]   i_req_exp;
    logic [CB-1:0]   i_req_ctl;
    logic            i_req_mode;
    logic            o_mul_val;
    logic            i_mul_rdy;
    logic [2*DB-1:0] o_mul_dat;
    logic [CB-1:0]   o_mul_ctl;
    logic            i_mul_val;
    logic            o_mul_rdy;
    logic [DB-1:0]   i_mul_dat;
    logic            o_res_val;
    logic            i_res_rdy;
    logic [DB-1:0]   o_res_dat;
    logic [CB-1:0]   o_res_ctl;
    logic            o_busy;

    always #5 clk = ~clk;

    fe_pow_engine #(
        .DAT_BITS (DB),
        .P        (P),
        .EXP_BITS (EB),
        .CTL_BITS (CB)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (i_rst_n),
        .i_req_val  (i_req_val),
        .o_req_rdy  (o_req_rdy),
        .i_req_dat  (i_req_dat),
        .i_req_exp  (i_req_exp),
        .i_req_ctl  (i_req_ctl),
        .i_req_mode (i_req_mode),
        .o_mul_val  (o_mul_val),
        .i_mul_rdy  (i_mul_rdy),
        .o_mul_dat  (o_mul_dat),
        .o_mul_ctl  (o_mul_ctl),
        .i_mul_val  (i_mul_val),
        .o_mul_rdy  (o_mul_rdy),
        .i_mul_dat  (i_mul_dat),
        .o_res_val  (o_res_val),
        .i_res_rdy  (i_res_rdy),
        .o_res_dat  (o_res_dat),
        .o_res_ctl  (o_res_ctl),
        .o_busy     (o_busy)
    );

    typedef struct {
        logic [DB-1:0] x;
        logic [DB-1:0] val;
        logic [CB-1:0] ctl;
        bit            inv;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk      = 0;
    int          n_pass     = 0;
    int          n_fail     = 0;
    int          n_mul      = 0;
    int          n_sqr      = 0;
    int          n_overlap  = 0;
    int          n_ctl_bad  = 0;
    int          n_unexp    = 0;
    bit          mul_toggle = 1'b0;
    logic [CB-1:0] cur_ctl  = '0;

    function automatic logic [DB-1:0] mulmod(input logic [DB-1:0] a, input logic [DB-1:0] b);
        logic [2*DB-1:0] t;
        t = (2*DB)'(a) * (2*DB)'(b);
        t = t % (2*DB)'(P);
        return t[DB-1:0];
    endfunction

    task automatic chk(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DB-1:0] x, input logic [DB-1:0] val,
                        input logic [CB-1:0] ctl, input bit inv);
        exp_t e;
        e.x   = x;
        e.val = val;
        e.ctl = ctl;
        e.inv = inv;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [DB-1:0] x, input logic [EB-1:0] e, input logic mode,
                        input logic [CB-1:0] ctl, input int budget);
        int cyc;
        @(posedge clk);
        #1;
        i_req_val  = 1'b1;
        i_req_dat  = x;
        i_req_exp  = e;
        i_req_mode = mode;
        i_req_ctl  = ctl;
        cyc = 0;
        @(negedge clk);
        while (!o_req_rdy && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk("req_accept", DB'(o_req_rdy), DB'(1));
        @(posedge clk);
        #1;
        i_req_val = 1'b0;
        cur_ctl   = ctl;
    endtask

    task automatic drain(input string tag, input int budget);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk(tag, DB'(exp_q.size()), '0);
        @(posedge clk);
        #1;
    endtask

    // Ideal multiplier: response appears the cycle after the request handshake.
    initial begin
        logic          rq;
        logic          rs;
        logic          rz;
        logic [DB-1:0] a;
        logic [DB-1:0] b;
        logic [CB-1:0] c;
        i_mul_val = 1'b0;
        i_mul_dat = '0;
        i_mul_rdy = 1'b1;
        forever begin
            @(negedge clk);
            rq = o_mul_val && i_mul_rdy && i_rst_n;
            rs = i_mul_val && o_mul_rdy && i_rst_n;
            rz = !i_rst_n;
            a  = o_mul_dat[DB-1:0];
            b  = o_mul_dat[2*DB-1:DB];
            c  = o_mul_ctl;
            if (rq && i_mul_val) n_overlap++;
            if (rq && c !== cur_ctl) n_ctl_bad++;
            @(posedge clk);
            #1;
            if (rs || rz) i_mul_val = 1'b0;
            if (rq) begin
                n_mul++;
                if (a == b) n_sqr++;
                i_mul_dat = mulmod(a, b);
                i_mul_val = 1'b1;
            end
            i_mul_rdy = mul_toggle ? !i_mul_rdy : 1'b1;
        end
    end

    // Result side of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (i_rst_n && o_res_val && i_res_rdy) begin
                if (exp_q.size() == 0) begin
                    n_unexp++;
                end else begin
                    e = exp_q.pop_front();
                    chk("res_ctl", DB'(o_res_ctl), DB'(e.ctl));
                    if (e.inv) chk("inv_product", mulmod(e.x, o_res_dat), DB'(1));
                    else       chk("res_dat", o_res_dat, e.val);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int            m0;
        int            s0;
        int            cyc;
        logic [383:0]  wide;
        logic [383:0]  wmod;
        logic [DB-1:0] x;

        i_rst_n    = 1'b0;
        i_req_val  = 1'b0;
        i_req_dat  = '0;
        i_req_exp  = '0;
        i_req_ctl  = '0;
        i_req_mode = 1'b0;
        i_res_rdy  = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_req_rdy", DB'(o_req_rdy), '0);
        chk("rst_mul_val", DB'(o_mul_val), '0);
        chk("rst_mul_rdy", DB'(o_mul_rdy), '0);
        chk("rst_res_val", DB'(o_res_val), '0);
        chk("rst_busy",    DB'(o_busy), '0);
        chk("rst_res_dat", o_res_dat, '0);
        chk("rst_res_ctl", DB'(o_res_ctl), '0);
        chk("rst_mul_dat_lo", o_mul_dat[DB-1:0], '0);
        chk("rst_mul_dat_hi", o_mul_dat[2*DB-1:DB], '0);
        chk("rst_mul_ctl", DB'(o_mul_ctl), '0);
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_before_edge", DB'(o_req_rdy), '0);
        @(posedge clk);
        #1;
        chk("rdy_after_edge", DB'(o_req_rdy), DB'(1));

        // Power, x=2 e=5: sqr, sqr, mul -> 32.
        m0 = n_mul;
        s0 = n_sqr;
        push('0, DB'(32), 64'h5, 1'b0);
        send(DB'(2), EB'(5), 1'b1, 64'h5, 20);
        chk("mul_val_after_accept", DB'(o_mul_val), DB'(1));
        chk("busy_running", DB'(o_busy), DB'(1));
        drain("pow5_drain", 200);
        chk("pow5_mul_count", DB'(n_mul - m0), DB'(3));
        chk("pow5_sqr_count", DB'(n_sqr - s0), DB'(2));

        // Power, e=0: result 1 the cycle after acceptance, no multiplier traffic.
        m0 = n_mul;
        push('0, DB'(1), 64'h7, 1'b0);
        send(DB'(7), '0, 1'b1, 64'h7, 20);
        chk("e0_res_val", DB'(o_res_val), DB'(1));
        chk("e0_mul_val", DB'(o_mul_val), '0);
        drain("e0_drain", 20);
        chk("e0_mul_count", DB'(n_mul - m0), '0);

        // Power, e=1: result x with no multiplier traffic.
        m0 = n_mul;
        push('0, DB'(9), 64'h11, 1'b0);
        send(DB'(9), EB'(1), 1'b1, 64'h11, 20);
        drain("e1_drain", 20);
        chk("e1_mul_count", DB'(n_mul - m0), '0);

        // Inverse of 2 is (P+1)/2.
        push('0, (P >> 1) + DB'(1), 64'h2, 1'b0);
        send(DB'(2), '0, 1'b0, 64'h2, 20);
        drain("inv2_drain", 5000);

        // Inverse of 0 is 0; tag carried through.
        push('0, '0, 64'hDEAD_BEEF, 1'b0);
        send('0, '0, 1'b0, 64'hDEAD_BEEF, 20);
        drain("inv0_drain", 5000);

        // Random inverses: x * x^-1 mod P == 1.
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 12; k++) wide[k*32 +: 32] = $urandom();
            wmod = wide % 384'(P);
            x    = wmod[DB-1:0];
            if (x == '0) x = DB'(1);
            push(x, '0, CB'(64'h1000 + i), 1'b1);
            send(x, '0, 1'b0, CB'(64'h1000 + i), 5000);
        end
        drain("inv_rand_drain", 5000);

        // Result back-pressure with a stuttering multiplier: 3^13 = 1594323.
        i_res_rdy  = 1'b0;
        mul_toggle = 1'b1;
        push('0, DB'(1594323), 64'h47, 1'b0);
        send(DB'(3), EB'(13), 1'b1, 64'h47, 20);
        cyc = 0;
        @(negedge clk);
        while (!o_res_val && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("stall_res_val", DB'(o_res_val), DB'(1));
            chk("stall_res_dat", o_res_dat, DB'(1594323));
            chk("stall_res_ctl", DB'(o_res_ctl), DB'(64'h47));
            chk("stall_req_rdy", DB'(o_req_rdy), '0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        i_res_rdy = 1'b1;
        drain("stall_drain", 50);
        mul_toggle = 1'b0;

        // Reset while waiting on a square response; aborted op emits nothing.
        send(DB'(5), EB'(12345), 1'b1, 64'h99, 20);
        cyc = 0;
        @(negedge clk);
        while (!o_mul_rdy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_in_wait", DB'(o_mul_rdy), DB'(1));
        #1;
        i_rst_n = 1'b0;
        #1;
        chk("abort_mul_rdy", DB'(o_mul_rdy), '0);
        chk("abort_busy", DB'(o_busy), '0);
        chk("abort_res_val", DB'(o_res_val), '0);
        chk("abort_mul_val", DB'(o_mul_val), '0);
        repeat (3) @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        push('0, DB'(81), 64'h81, 1'b0);
        send(DB'(3), EB'(4), 1'b1, 64'h81, 20);
        drain("after_rst_drain", 200);

        chk("unexpected_results", DB'(n_unexp), '0);
        chk("outstanding_overlap", DB'(n_overlap), '0);
        chk("mul_ctl_mismatch", DB'(n_ctl_bad), '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
